demux1to8_16bits_reg: RTL and testbench

- Registered 1-to-8 demultiplexer for 16-bit words. It is the write-side counterpart of the 8-to-1 16-bit select mux in the RISC-V datapath.
- A single producer stream carries a 3-bit destination select. Each accepted word is steered into one of eight per-channel holding registers.
- Each channel presents its word to its own consumer with a valid/ready handshake.
- Used to fan write-back and forwarding results out to per-unit latches without combinational fan-out timing.

---
 rtl/demux1to8_16bits_reg_if.sv | 31 +++
 rtl/demux1to8_16bits_reg.sv | 69 ++++++
 tb/tb_demux1to8_16bits_reg.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/demux1to8_16bits_reg_if.sv
// Producer and per-channel consumer bundle for the registered 1-to-8 demux.
// When DEMUX_BROADCAST_EN is defined, the producer side also carries in_bcast.
interface demux1to8_16bits_reg_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
);
    localparam int NUM_CH = 1 << SEL_W;

    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
`ifdef DEMUX_BROADCAST_EN
    logic                     in_bcast;
`endif
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

`ifdef DEMUX_BROADCAST_EN
    modport master (output in_valid, in_data, in_sel, in_bcast, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_sel, in_bcast, out_ready,
                    output in_ready, out_valid, out_data);
`else
    modport master (output in_valid, in_data, in_sel, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_sel, out_ready,
                    output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/demux1to8_16bits_reg.sv
// Registered 1-to-8 demux of 16-bit words; DEMUX_BROADCAST_EN adds broadcast loads.
// Latency: 1 cycle from accept to out_valid/out_data of the target channel.
// Backpressure: in_ready drops only while the target channel(s) is full and not draining.
module demux1to8_16bits_reg #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1to8_16bits_reg_if.slave bus,
    output logic [SEL_W-1:0]     last_sel,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int NUM_CH = 1 << SEL_W;

    logic [NUM_CH-1:0] valid_q;
    logic [DATA_W-1:0] word_q [NUM_CH];
    logic [NUM_CH-1:0] can_take;
    logic [NUM_CH-1:0] load;
    logic              in_rdy;
    logic              accept;

    // A channel can take a word when empty or when it drains on this same edge.
    assign can_take = ~valid_q | bus.out_ready;

    always_comb begin
        in_rdy = can_take[bus.in_sel];
`ifdef DEMUX_BROADCAST_EN
        if (bus.in_bcast) in_rdy = &can_take;
`endif
    end

    assign accept = bus.in_valid & in_rdy;

    always_comb begin
        load = '0;
        if (accept) begin
            load[bus.in_sel] = 1'b1;
`ifdef DEMUX_BROADCAST_EN
            if (bus.in_bcast) load = '1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            last_sel  <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) word_q[k] <= '0;
        end else begin
            valid_q <= load | (valid_q & ~bus.out_ready);
            for (int k = 0; k < NUM_CH; k++) begin
                if (load[k]) word_q[k] <= bus.in_data;
            end
            if (accept) last_sel <= bus.in_sel;
            if (bus.in_valid && !in_rdy && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = valid_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign bus.out_data[k*DATA_W +: DATA_W] = word_q[k];
    end
endmodule

// File: tb/tb_demux1to8_16bits_reg.sv
// Directed bench for demux1to8_16bits_reg with a per-cycle reference model.
// A second instance built with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_demux1to8_16bits_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux1to8_16bits_reg_if #(.DATA_W(16), .SEL_W(3)) bus ();
    demux1to8_16bits_reg_if #(.DATA_W(16), .SEL_W(3)) bus4 ();

    logic [2:0]  last_sel, last_sel4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    demux1to8_16bits_reg #(.DATA_W(16), .SEL_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .last_sel(last_sel), .stall_cnt(stall_cnt));
    demux1to8_16bits_reg #(.DATA_W(16), .SEL_W(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .last_sel(last_sel4), .stall_cnt(stall_cnt4));

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.in_sel    = bus.in_sel;
    assign bus4.out_ready = bus.out_ready;
`ifdef DEMUX_BROADCAST_EN
    assign bus4.in_bcast  = bus.in_bcast;
`endif

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: per-channel occupancy and word, plus an unbounded stall tally.
    bit          m_valid [8];
    logic [15:0] m_data  [8];
    int          m_last;
    int          m_stalls;

    function automatic bit m_bcast();
`ifdef DEMUX_BROADCAST_EN
        return bus.in_bcast === 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        bit r;
        r = 1'b1;
        for (int k = 0; k < 8; k++)
            if ((m_bcast() || k == int'(bus.in_sel)) && m_valid[k] && !bus.out_ready[k]) r = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin m_valid[k] = 1'b0; m_data[k] = '0; end
            m_last = 0;
            m_stalls = 0;
        end else begin
            bit rdy, bc;
            int s;
            rdy = exp_ready();
            bc  = m_bcast();
            s   = int'(bus.in_sel);
            for (int k = 0; k < 8; k++) if (m_valid[k] && bus.out_ready[k]) m_valid[k] = 1'b0;
            if (bus.in_valid && rdy) begin
                for (int k = 0; k < 8; k++)
                    if (bc || k == s) begin m_valid[k] = 1'b1; m_data[k] = bus.in_data; end
                m_last = s;
            end
            if (bus.in_valid && !rdy) m_stalls++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [127:0] e_data;
            logic [7:0]   e_valid;
            for (int k = 0; k < 8; k++) begin
                e_data[k*16 +: 16] = m_data[k];
                e_valid[k] = m_valid[k];
            end
            check("cyc_out_valid", 128'(bus.out_valid), 128'(e_valid));
            check("cyc_out_data", bus.out_data, e_data);
            check("cyc_last_sel", 128'(last_sel), 128'(m_last));
            check("cyc_stall_cnt", 128'(stall_cnt), 128'(m_stalls > 65535 ? 65535 : m_stalls));
            check("cyc_stall_cnt4", 128'(stall_cnt4), 128'(m_stalls > 15 ? 15 : m_stalls));
            if (bus.in_valid) check("cyc_in_ready", 128'(bus.in_ready), 128'(exp_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ch(input int k);
        return bus.out_data[k*16 +: 16];
    endfunction

    logic [15:0] sweep_d [8] = '{16'd65535, 16'd11, 16'd5, 16'd15155, 16'd2222, 16'd8, 16'd8, 16'd10};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
        bus.in_bcast = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 128'(bus.out_valid), 128'h0);
        check("rst_out_data", bus.out_data, 128'h0);
        check("rst_stall_cnt", 128'(stall_cnt), 128'h0);
        rst_n = 1'b1;
        step();

        // Sweep all channels with consumers blocked.
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1; bus.in_sel = 3'(k); bus.in_data = sweep_d[k];
            step();
            check("sweep_data", 128'(ch(k)), 128'(sweep_d[k]));
            check("sweep_valid", 128'(bus.out_valid), 128'((1 << (k + 1)) - 1));
        end
        bus.in_valid = 1'b0;
        check("sweep_last_sel", 128'(last_sel), 128'd7);

        // Back-pressure on a full channel 3.
        bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 16'd1234;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
            step();
        end
        check("bp_stall_cnt", 128'(stall_cnt), 128'd5);
        check("bp_hold", 128'(ch(3)), 128'd15155);
        bus.out_ready = 8'h08;
        #1 check("bp_release_ready", 128'(bus.in_ready), 128'd1);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 8'h00;
        check("bp_no_bubble_valid", 128'(bus.out_valid), 128'hFF);
        check("bp_new_word", 128'(ch(3)), 128'd1234);
        check("bp_stall_held", 128'(stall_cnt), 128'd5);

        // Free channel 4, then load it while channel 3 stays blocked.
        bus.out_ready = 8'h10;
        step();
        bus.out_ready = 8'h00;
        check("drain4_valid", 128'(bus.out_valid), 128'hEF);
        bus.in_valid = 1'b1; bus.in_sel = 3'd4; bus.in_data = 16'd2222;
        #1 check("indep_ready", 128'(bus.in_ready), 128'd1);
        step();
        bus.in_valid = 1'b0;
        check("indep_valid", 128'(bus.out_valid), 128'hFF);
        check("indep_ch4", 128'(ch(4)), 128'd2222);
        check("indep_ch3", 128'(ch(3)), 128'd1234);
        check("indep_last_sel", 128'(last_sel), 128'd4);

        // Multi-channel drain; data is retained.
        bus.out_ready = 8'hA5;
        step();
        bus.out_ready = 8'h00;
        check("drain_valid", 128'(bus.out_valid), 128'h5A);
        check("drain_ch0_kept", 128'(ch(0)), 128'd65535);
        check("drain_ch7_kept", 128'(ch(7)), 128'd10);

        // Long stall on full channel 1.
        bus.in_valid = 1'b1; bus.in_sel = 3'd1; bus.in_data = 16'd7;
        repeat (20) step();
        bus.in_valid = 1'b0;
        check("sat_cnt4", 128'(stall_cnt4), 128'd15);
        check("sat_cnt16", 128'(stall_cnt), 128'd25);
        check("sat_ch1_kept", 128'(ch(1)), 128'd11);

        // Asynchronous reset between edges with channels full.
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(bus.out_valid), 128'h0);
        check("arst_out_data", bus.out_data, 128'h0);
        check("arst_stall_cnt", 128'(stall_cnt), 128'h0);
        check("arst_last_sel", 128'(last_sel), 128'h0);
        step();
        #2 rst_n = 1'b1;
        step();

`ifdef DEMUX_BROADCAST_EN
        bus.in_valid = 1'b1; bus.in_bcast = 1'b1; bus.in_sel = 3'd2; bus.in_data = 16'hBEEF;
        #1 check("bc_ready", 128'(bus.in_ready), 128'd1);
        step();
        bus.in_valid = 1'b0;
        check("bc_valid", 128'(bus.out_valid), 128'hFF);
        check("bc_data", bus.out_data, {8{16'hBEEF}});
        check("bc_last_sel", 128'(last_sel), 128'd2);
        bus.out_ready = 8'hBF;
        bus.in_valid = 1'b1; bus.in_data = 16'h1111;
        #1 check("bc_blocked", 128'(bus.in_ready), 128'd0);
        step();
        bus.in_valid = 1'b0; bus.in_bcast = 1'b0; bus.out_ready = 8'h00;
        check("bc_blocked_valid", 128'(bus.out_valid), 128'h40);
        step();
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
